// File: rtl/kf_pkg.sv
// kf_pkg: shared types and constants for the Kalman-gain divider path.
//   FP_W              width of an IEEE-754 single
//   FP_EXP_MANT_MASK  exponent+mantissa bits (everything except the sign)
//   DIV_LAT_DFLT      default latency of the floating-point divider IP
//   fp32_t            raw single-precision bit pattern
//   res_entry_t       one result FIFO entry: divide-by-zero flag + quotient
package kf_pkg;

  localparam int          FP_W             = 32;
  localparam logic [30:0] FP_EXP_MANT_MASK = 31'h7FFF_FFFF;
  localparam int          DIV_LAT_DFLT     = 28;

  typedef logic [FP_W-1:0] fp32_t;

  typedef struct packed {
    logic  dz;
    fp32_t q;
  } res_entry_t;

  // +0 and -0 count as zero; subnormals do not.
  function automatic logic fp_is_zero(input fp32_t x);
    return (x[30:0] & FP_EXP_MANT_MASK) == 31'd0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count.
//   clock, resetn  clock and synchronous active-low reset (clears pointers/count)
//   i_wr, i_wdata  push; ignored when full unless a pop happens the same cycle
//   i_rd           pop the head; ignored when empty
//   o_rdata        current head (valid whenever o_count != 0)
//   o_count        number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic [AW:0]  o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_do_rd;
  logic w_do_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_do_rd = i_rd && !w_empty;
  // A pop frees the slot in the same cycle, so write+pop is legal when full.
  assign w_do_wr = i_wr && (!w_full || w_do_rd);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue/credit/flush controller in front of the fixed-latency
// floating-point divider used for the Kalman gain.
//   clock, resetn            clock, synchronous active-low reset
//   s_num/s_den/s_valid/s_ready   operand pair input (valid/ready)
//   div_a/div_b/div_valid    registered issue port to the divider
//   div_result/_valid        divider return (no backpressure)
//   m_result/m_dz/m_valid/m_ready show-ahead result output
//   inflight                 issued-but-not-returned operation count
//   flushing                 post-reset window in which divider returns are dropped
module div_issue_ctrl
  import kf_pkg::*;
#(
  parameter int DIV_LAT = kf_pkg::DIV_LAT_DFLT,
  parameter int DEPTH   = 8,
  parameter int AW      = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  fp32_t       s_num,
  input  fp32_t       s_den,
  input  logic        s_valid,
  output logic        s_ready,
  output fp32_t       div_a,
  output fp32_t       div_b,
  output logic        div_valid,
  input  fp32_t       div_result,
  input  logic        div_result_valid,
  output fp32_t       m_result,
  output logic        m_dz,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [AW:0] inflight,
  output logic        flushing
);

  localparam int             FCW        = $clog2(DIV_LAT + 2);
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(DIV_LAT + 1);

  logic [FCW-1:0] r_flush_cnt;
  logic [AW:0]    r_inflight;
  fp32_t          r_div_a;
  fp32_t          r_div_b;
  logic           r_div_valid;

  logic        w_flushing;
  logic [AW+1:0] w_used;
  logic        w_issue;
  logic        w_ret;
  logic        w_pop;
  logic        w_dz_head;
  logic [AW:0] w_dz_count;
  logic [AW:0] w_res_count;
  res_entry_t  w_wr_entry;
  res_entry_t  w_head;

  assign w_flushing = (r_flush_cnt != '0);
  // Credits cover both in-flight ops and parked results, so the FIFO can never overflow.
  assign w_used     = {1'b0, r_inflight} + {1'b0, w_res_count};
  assign s_ready    = !w_flushing && (w_used < (AW+2)'(DEPTH));
  assign w_issue    = s_valid && s_ready;
  // The divider has no reset: anything it returns during the flush window is stale.
  assign w_ret      = div_result_valid && !w_flushing;
  assign w_pop      = m_valid && m_ready;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_flush_cnt <= FLUSH_INIT;
      r_inflight  <= '0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_div_valid <= 1'b0;
    end else begin
      if (w_flushing) begin
        r_flush_cnt <= r_flush_cnt - 1'b1;
      end
      r_div_valid <= w_issue;
      if (w_issue) begin
        r_div_a <= s_num;
        r_div_b <= s_den;
      end
      unique case ({w_issue, w_ret})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Per-op zero-denominator flags, kept in issue order alongside the divider pipe.
  sync_fifo #(
    .W     (1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dz_q (
    .clock   (clock),
    .resetn  (resetn),
    .i_wr    (w_issue),
    .i_wdata (fp_is_zero(s_den)),
    .i_rd    (w_ret),
    .o_rdata (w_dz_head),
    .o_count (w_dz_count)
  );

  assign w_wr_entry.dz = w_dz_head && (w_dz_count != '0);
  assign w_wr_entry.q  = div_result;

  sync_fifo #(
    .W     ($bits(res_entry_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_res_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .i_wr    (w_ret),
    .i_wdata (w_wr_entry),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_count (w_res_count)
  );

  assign m_valid   = (w_res_count != '0);
  // Head is masked when empty so stale RAM contents never show on m_*.
  assign m_result  = m_valid ? w_head.q : '0;
  assign m_dz      = m_valid && w_head.dz;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign div_valid = r_div_valid;
  assign inflight  = r_inflight;
  assign flushing  = w_flushing;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  localparam int DIV_LAT = 28;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] s_num, s_den;
  logic        s_valid, s_ready;
  logic [31:0] div_a, div_b;
  logic        div_valid;
  logic [31:0] div_result;
  logic        div_result_valid;
  logic [31:0] m_result;
  logic        m_dz, m_valid, m_ready;
  logic [AW:0] inflight;
  logic        flushing;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pop    = 0;
  int n_trip   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  div_issue_ctrl #(.DIV_LAT(DIV_LAT), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .s_num            (s_num),
    .s_den            (s_den),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .div_a            (div_a),
    .div_b            (div_b),
    .div_valid        (div_valid),
    .div_result       (div_result),
    .div_result_valid (div_result_valid),
    .m_result         (m_result),
    .m_dz             (m_dz),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .inflight         (inflight),
    .flushing         (flushing)
  );

  // Behavioural divider: known pairs give the true IEEE quotient, others a fixed scramble.
  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3F800000 && b == 32'h80000000) return 32'hFF800000;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  logic [DIV_LAT-1:0] pv = '0;
  logic [31:0] pa [DIV_LAT];
  logic [31:0] pb [DIV_LAT];
  always @(posedge clock) begin
    pv    <= {pv[DIV_LAT-2:0], div_valid};
    pa[0] <= div_a;
    pb[0] <= div_b;
    for (int i = 1; i < DIV_LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign div_result_valid = pv[DIV_LAT-1];
  assign div_result       = div_model(pa[DIV_LAT-1], pb[DIV_LAT-1]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard / protocol monitor, sampling on the falling edge.
  logic [32:0] exp_q[$];
  initial begin : mon
    logic [32:0] e;
    logic        hold_v, trip_v, ret_now;
    logic [32:0] hold_val;
    logic [AW:0] trip_infl, trip_cnt;
    hold_v = 1'b0;
    trip_v = 1'b0;
    hold_val = '0;
    trip_infl = '0;
    trip_cnt = '0;
    forever begin
      @(negedge clock);
      if (resetn !== 1'b1) begin
        exp_q.delete();
        hold_v = 1'b0;
        trip_v = 1'b0;
      end else begin
        if (hold_v && m_valid)
          chk("hold_stable", 64'({m_dz, m_result}), 64'(hold_val));
        if (trip_v) begin
          chk("trip_inflight", 64'(inflight), 64'(trip_infl));
          chk("trip_count", 64'(dut.w_res_count), 64'(trip_cnt));
        end
        ret_now = div_result_valid && !flushing;
        if (ret_now)
          chk("no_full_wr", 64'((dut.w_res_count == (AW+1)'(DEPTH)) && !(m_valid && m_ready)), 64'd0);
        if (s_valid && s_ready) begin
          exp_q.push_back({s_den[30:0] == 31'd0, div_model(s_num, s_den)});
          chk("inflight_le_depth", 64'(inflight < (AW+1)'(DEPTH)), 64'd1);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_extra_pop", 64'(m_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_result", 64'(m_result), 64'(e[31:0]));
            chk("sb_dz", 64'(m_dz), 64'(e[32]));
          end
          n_pop++;
        end
        trip_v    = s_valid && s_ready && ret_now && m_valid && m_ready;
        trip_infl = inflight;
        trip_cnt  = dut.w_res_count;
        if (trip_v) n_trip++;
        hold_v   = m_valid && !m_ready;
        hold_val = {m_dz, m_result};
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic reset_dut(input int cycles);
    @(posedge clock);
    #2 resetn = 1'b0;
    repeat (cycles) @(posedge clock);
    #2 resetn = 1'b1;
  endtask

  // Called 2 time units after a rising edge; returns likewise, after the accepting edge.
  task automatic send(input logic [31:0] n, input logic [31:0] d);
    int t;
    t = 0;
    s_num = n;
    s_den = d;
    s_valid = 1'b1;
    @(negedge clock);
    while (!s_ready && t < 200) begin
      t++;
      @(negedge clock);
    end
    chk("send_accept", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  task automatic wait_mv();
    int t;
    t = 0;
    @(negedge clock);
    while (!m_valid && t < 100) begin
      t++;
      @(negedge clock);
    end
    chk("wait_m_valid", 64'(m_valid), 64'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clock);
    while ((m_valid || inflight != '0) && t < 300) begin
      t++;
      @(negedge clock);
    end
    chk("drain_done", 64'(m_valid || inflight != '0), 64'd0);
  endtask

  function automatic logic [31:0] tp_den(input int k);
    case (k % 10)
      3:       return 32'h0000_0001;
      7:       return 32'h0000_0000;
      9:       return 32'h8000_0000;
      default: return 32'h4000_0000 + 32'(k);
    endcase
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, acc, extra, stale, mv_seen, p0, tr0, a_cyc, dv_n, dv_c, mv_c, t;
    logic [31:0] dva, dvb;
    resetn = 1'b0; s_valid = 1'b0; s_num = '0; s_den = '0; m_ready = 1'b0;

    // Reset values and flush window length
    reset_dut(2);
    @(negedge clock);
    chk("rst_div_valid", 64'(div_valid), 64'd0);
    chk("rst_div_a", 64'(div_a), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_result", 64'(m_result), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    n = 0;
    while (flushing && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("flush_len", 64'(n), 64'd29);
    chk("ready_after_flush", 64'(s_ready), 64'd1);

    // Single op: 6.0 / 2.0
    step();
    send(32'h40C00000, 32'h40000000);
    a_cyc = cyc - 1;
    dv_n = 0; dv_c = -1; mv_c = -1; dva = '0; dvb = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (div_valid) begin
        dv_n++;
        if (dv_c < 0) begin dv_c = cyc; dva = div_a; dvb = div_b; end
      end
      if (m_valid && mv_c < 0) mv_c = cyc;
    end
    chk("t1_dv_pulses", 64'(dv_n), 64'd1);
    chk("t1_dv_latency", 64'(dv_c - a_cyc), 64'd1);
    chk("t1_div_a", 64'(dva), 64'h40C00000);
    chk("t1_div_b", 64'(dvb), 64'h40000000);
    chk("t1_div_a_hold", 64'(div_a), 64'h40C00000);
    chk("t1_mv_latency", 64'(mv_c - a_cyc), 64'd30);
    chk("t1_result", 64'(m_result), 64'h40400000);
    chk("t1_dz", 64'(m_dz), 64'd0);
    chk("t1_inflight", 64'(inflight), 64'd0);
    step();
    pop_one();
    @(negedge clock);
    chk("t1_empty", 64'(m_valid), 64'd0);

    // Zero / normal / subnormal denominators, in order
    step();
    send(32'h3F800000, 32'h80000000);
    send(32'h3F800000, 32'h3F800000);
    send(32'h3F800000, 32'h00000001);
    wait_mv();
    chk("t2_q0", 64'(m_result), 64'hFF800000);
    chk("t2_dz0", 64'(m_dz), 64'd1);
    step(); pop_one();
    @(negedge clock);
    chk("t2_q1", 64'(m_result), 64'h3F800000);
    chk("t2_dz1", 64'(m_dz), 64'd0);
    step(); pop_one();
    @(negedge clock);
    chk("t2_q2_subnormal", 64'(m_result), 64'h3F810000);
    chk("t2_dz2_subnormal", 64'(m_dz), 64'd0);
    step(); pop_one();
    @(negedge clock);
    chk("t2_empty", 64'(m_valid), 64'd0);

    // Credit stall with m_ready low
    step();
    p0 = n_pop;
    acc = 0;
    s_num = 32'h41000000; s_den = 32'h40800000; s_valid = 1'b1;
    repeat (50) begin
      @(negedge clock);
      if (s_ready) acc++;
      step();
      s_num = 32'h41000000 + 32'(acc);
      s_den = 32'h40800000 + 32'(acc << 4);
    end
    @(negedge clock);
    chk("t3_accepts", 64'(acc), 64'd8);
    chk("t3_s_ready", 64'(s_ready), 64'd0);
    chk("t3_credit_sum", 64'(inflight) + 64'(dut.w_res_count), 64'd8);
    chk("t3_inflight", 64'(inflight), 64'd0);
    step();
    m_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (s_ready) extra++;
      step();
      m_ready = 1'b0;
      s_num = 32'h41000000 + 32'(acc + extra);
      s_den = 32'h40800000 + 32'((acc + extra) << 4);
    end
    chk("t3_extra_accepts", 64'(extra), 64'd1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    drain();
    step();
    chk("t3_pops", 64'(n_pop - p0), 64'd9);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Back-to-back stream with m_ready high
    p0 = n_pop; tr0 = n_trip; acc = 0; t = 0;
    s_num = 32'h3F000000; s_den = tp_den(0); s_valid = 1'b1;
    while (acc < 100 && t < 2000) begin
      @(negedge clock);
      if (s_ready) acc++;
      step();
      s_num = 32'h3F000000 + 32'(acc << 8);
      s_den = tp_den(acc);
      t++;
    end
    s_valid = 1'b0;
    drain();
    step();
    chk("t4_accepts", 64'(acc), 64'd100);
    chk("t4_pops", 64'(n_pop - p0), 64'd100);
    chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t4_triple_seen", 64'(n_trip > tr0), 64'd1);

    // Reset while three ops are in flight
    m_ready = 1'b0;
    send(32'h41200000, 32'h40000000);
    send(32'h41300000, 32'h40000000);
    send(32'h41400000, 32'h00000000);
    step();
    reset_dut(1);
    @(negedge clock);
    n = 0; stale = 0; mv_seen = 0;
    while (flushing && n < 100) begin
      n++;
      if (div_result_valid) stale++;
      if (m_valid) mv_seen++;
      @(negedge clock);
    end
    chk("t5_flush_len", 64'(n), 64'd29);
    chk("t5_stale_seen", 64'(stale), 64'd3);
    chk("t5_inflight", 64'(inflight), 64'd0);
    repeat (10) begin
      if (m_valid) mv_seen++;
      @(negedge clock);
    end
    chk("t5_m_valid_quiet", 64'(mv_seen), 64'd0);
    chk("t5_s_ready", 64'(s_ready), 64'd1);
    step();
    p0 = n_pop;
    m_ready = 1'b1;
    send(32'h40C00000, 32'h40000000);
    drain();
    step();
    chk("t5_recover_pops", 64'(n_pop - p0), 64'd1);
    chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
